sp_dram_arbiter: RTL and testbench

Round-robin arbiter that shares one sp_dram port (26-bit word address, 128-bit data, 16-bit byte mask, we/re/ready) among PORTS requesters. Each requester issues one single-word read or write at a time with a req/ack handshake. The arbiter latches the winning request, drives a one-cycle we/re pulse to the memory, tracks read completion via mem_ready, and returns read data. It sits between kernel memory interfaces and sp_dram in generated designs.

---
 rtl/sp_dram_arbiter.sv | 266 ++++++++++++++++++++++++++
 tb/tb_sp_dram_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sp_dram_arbiter.sv
// sp_dram_arbiter
//   Shares a single sp_dram port among PORTS requesters. Each requester holds
//   req_in high with stable fields until it sees a one-cycle ack_out pulse.
//   The arbiter latches the winning request, fires a one-cycle mem_we or
//   mem_re, waits for read completion through mem_ready and returns the read
//   data on dout_out, which holds until the next read completes.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   req_in       : per-port request (PORTS)
//   we_in        : per-port op, 1 = write, 0 = read (PORTS)
//   addr_in      : per-port word address, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   din_in       : per-port write data, packed like addr_in
//   mask_in      : per-port byte mask (1 = byte written), packed like addr_in
//   ack_out      : one-hot, one-cycle completion pulse
//   dout_out     : read data, valid from the ack cycle of a read
//   mem_addr/mem_din/mem_mask/mem_we/mem_re : command side of sp_dram
//   mem_dout/mem_ready                      : response side of sp_dram
//
// Configuration macro
//   SP_DRAM_ARB_FIXED_PRIO_EN : when defined, the lowest-numbered requesting
//   port always wins and the round-robin pointer does not exist. When
//   undefined, the search starts at the round-robin pointer and wraps.

module sp_dram_arbiter #(
  parameter int PORTS      = 2,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 128,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS-1:0]            req_in,
  input  logic [PORTS-1:0]            we_in,
  input  logic [PORTS*ADDR_WIDTH-1:0] addr_in,
  input  logic [PORTS*DATA_WIDTH-1:0] din_in,
  input  logic [PORTS*MASK_WIDTH-1:0] mask_in,
  output logic [PORTS-1:0]            ack_out,
  output logic [DATA_WIDTH-1:0]       dout_out,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_din,
  output logic [MASK_WIDTH-1:0]       mem_mask,
  output logic                        mem_we,
  output logic                        mem_re,
  input  logic [DATA_WIDTH-1:0]       mem_dout,
  input  logic                        mem_ready
);

  localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_SETTLE    = 3'd2,
    S_READ_WAIT = 3'd3,
    S_ACK       = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic                    op_we_q, op_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_din_q, mem_din_d;
  logic [MASK_WIDTH-1:0]   mem_mask_q, mem_mask_d;
  logic                    mem_we_q, mem_we_d;
  logic                    mem_re_q, mem_re_d;
  logic [PORTS-1:0]        ack_q, ack_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;

  logic [IDX_W-1:0]        pick_s;
  logic                    pick_we_s;
  logic [ADDR_WIDTH-1:0]   pick_addr_s;
  logic [DATA_WIDTH-1:0]   pick_din_s;
  logic [MASK_WIDTH-1:0]   pick_mask_s;

`ifndef SP_DRAM_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]        rr_q, rr_d;
  logic [PORTS-1:0]        req_hi_s;
`endif

  // Index of the lowest set bit of v (0 when v is empty).
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [PORTS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Winner selection: fixed priority, or first requester at/after rr_q with wrap.
`ifdef SP_DRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    pick_s = lowest_idx(req_in);
  end
`else
  always_comb begin
    req_hi_s = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (IDX_W'(i) >= rr_q) begin
        req_hi_s[i] = req_in[i];
      end else begin
        req_hi_s[i] = 1'b0;
      end
    end
    // Requesters at or above the pointer take precedence; otherwise wrap to 0.
    if (|req_hi_s) begin
      pick_s = lowest_idx(req_hi_s);
    end else begin
      pick_s = lowest_idx(req_in);
    end
  end
`endif

  // Field mux for the selected port.
  always_comb begin
    pick_we_s   = 1'b0;
    pick_addr_s = '0;
    pick_din_s  = '0;
    pick_mask_s = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (pick_s == IDX_W'(i)) begin
        pick_we_s   = we_in[i];
        pick_addr_s = addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
        pick_din_s  = din_in[i*DATA_WIDTH +: DATA_WIDTH];
        pick_mask_s = mask_in[i*MASK_WIDTH +: MASK_WIDTH];
      end else begin
        pick_we_s   = pick_we_s;
        pick_addr_s = pick_addr_s;
        pick_din_s  = pick_din_s;
        pick_mask_s = pick_mask_s;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      op_we_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_mask_q <= '0;
      mem_we_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      ack_q      <= '0;
      dout_q     <= '0;
`ifndef SP_DRAM_ARB_FIXED_PRIO_EN
      rr_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      op_we_q    <= op_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_mask_q <= mem_mask_d;
      mem_we_q   <= mem_we_d;
      mem_re_q   <= mem_re_d;
      ack_q      <= ack_d;
      dout_q     <= dout_d;
`ifndef SP_DRAM_ARB_FIXED_PRIO_EN
      rr_q       <= rr_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        // mem_ready low means sp_dram cannot take a command: grant nothing.
        if (mem_ready && (|req_in)) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (op_we_q) begin
          state_d = S_ACK;
        end else begin
          state_d = S_SETTLE;
        end
      end
      // sp_dram only drops ready the cycle after re, so ready cannot be
      // trusted as "done" until one cycle later.
      S_SETTLE: state_d = S_READ_WAIT;
      S_READ_WAIT: begin
        if (mem_ready) begin
          state_d = S_ACK;
        end else begin
          state_d = S_READ_WAIT;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and latched request fields.
  always_comb begin
    grant_d    = grant_q;
    op_we_d    = op_we_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_mask_d = mem_mask_q;
    mem_we_d   = 1'b0;
    mem_re_d   = 1'b0;
    dout_d     = dout_q;
`ifndef SP_DRAM_ARB_FIXED_PRIO_EN
    rr_d       = rr_q;
`endif

    // ISSUE is only entered from IDLE, so this is the grant edge.
    if (state_d == S_ISSUE) begin
      grant_d    = pick_s;
      op_we_d    = pick_we_s;
      mem_addr_d = pick_addr_s;
      mem_din_d  = pick_din_s;
      mem_mask_d = pick_mask_s;
      mem_we_d   = pick_we_s;
      mem_re_d   = ~pick_we_s;
    end else begin
      grant_d    = grant_q;
      op_we_d    = op_we_q;
    end

    if ((state_q == S_READ_WAIT) && mem_ready) begin
      dout_d = mem_dout;
    end else begin
      dout_d = dout_q;
    end

    for (int i = 0; i < PORTS; i++) begin
      ack_d[i] = (state_d == S_ACK) && (grant_q == IDX_W'(i));
    end

`ifndef SP_DRAM_ARB_FIXED_PRIO_EN
    if (state_q == S_ACK) begin
      if (grant_q == IDX_W'(PORTS - 1)) begin
        rr_d = '0;
      end else begin
        rr_d = grant_q + IDX_W'(1);
      end
    end else begin
      rr_d = rr_q;
    end
`endif
  end

  assign ack_out  = ack_q;
  assign dout_out = dout_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_mask = mem_mask_q;
  assign mem_we   = mem_we_q;
  assign mem_re   = mem_re_q;

endmodule

// File: tb/tb_sp_dram_arbiter.sv
// Randomized bench for sp_dram_arbiter. Requesters and an sp_dram responder
// are driven from random choices; a transaction-level reference model,
// tracking only "busy", the granted transaction and the cycle numbers at which
// issue/ack must happen, predicts every output for every cycle.

module tb_sp_dram_arbiter;

  localparam int P  = 3;
  localparam int AW = 26;
  localparam int DW = 128;
  localparam int MW = DW / 8;
  localparam int NCYC = 4000;

  logic              clk;
  logic              rst;
  logic [P-1:0]      req_in;
  logic [P-1:0]      we_in;
  logic [P*AW-1:0]   addr_in;
  logic [P*DW-1:0]   din_in;
  logic [P*MW-1:0]   mask_in;
  logic [P-1:0]      ack_out;
  logic [DW-1:0]     dout_out;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_din;
  logic [MW-1:0]     mem_mask;
  logic              mem_we;
  logic              mem_re;
  logic [DW-1:0]     mem_dout;
  logic              mem_ready;

  sp_dram_arbiter #(
    .PORTS(P), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_in(req_in), .we_in(we_in), .addr_in(addr_in),
    .din_in(din_in), .mask_in(mask_in),
    .ack_out(ack_out), .dout_out(dout_out),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_mask(mem_mask),
    .mem_we(mem_we), .mem_re(mem_re),
    .mem_dout(mem_dout), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got,
                          input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Requester state
  logic          r_act  [P];
  logic          r_we   [P];
  logic [AW-1:0] r_addr [P];
  logic [DW-1:0] r_din  [P];
  logic [MW-1:0] r_mask [P];

  // Reference model state and expected outputs for the current cycle
  logic          m_busy;
  int            m_port;
  logic          m_we;
  int            m_ack_at;
  int            m_wait_from;
  int            m_rr;
  logic [P-1:0]  e_ack;
  logic          e_we, e_re;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din;
  logic [MW-1:0] e_mask;
  logic [DW-1:0] e_dout;
  int            model_acks;
  int            dut_acks;
  logic          force_low;
  int            bp_left;

  task automatic new_request(input int p);
    r_act[p]  = 1'b1;
    r_we[p]   = ($urandom % 2) == 0;
    r_addr[p] = AW'($urandom);
    r_din[p]  = {$urandom, $urandom, $urandom, $urandom};
    r_mask[p] = MW'($urandom);
  endtask

  task automatic drive_ports();
    for (int p = 0; p < P; p++) begin
      req_in[p]              = r_act[p];
      we_in[p]               = r_we[p];
      addr_in[p*AW +: AW]    = r_addr[p];
      din_in[p*DW +: DW]     = r_din[p];
      mask_in[p*MW +: MW]    = r_mask[p];
    end
  endtask

  // Advance the model by one cycle using the inputs driven in cycle n;
  // leaves e_* holding the outputs expected in cycle n+1.
  task automatic model_step(input int n);
    int win;
    if (rst) begin
      m_busy = 1'b0; m_rr = 0; m_ack_at = -1;
      e_ack = '0; e_we = 1'b0; e_re = 1'b0;
      e_addr = '0; e_din = '0; e_mask = '0; e_dout = '0;
    end else begin
      e_ack = '0; e_we = 1'b0; e_re = 1'b0;
      if (m_busy && m_ack_at >= 0 && n > m_ack_at) m_busy = 1'b0;
      if (!m_busy) begin
        if (mem_ready && (req_in != '0)) begin
          win = -1;
          for (int k = 0; k < P; k++) begin
`ifdef SP_DRAM_ARB_FIXED_PRIO_EN
            if (win < 0 && r_act[k]) win = k;
`else
            if (win < 0 && r_act[(m_rr + k) % P]) win = (m_rr + k) % P;
`endif
          end
          m_busy = 1'b1;
          m_port = win;
          m_we   = r_we[win];
          e_addr = r_addr[win];
          e_din  = r_din[win];
          e_mask = r_mask[win];
          e_we   = m_we;
          e_re   = !m_we;
          if (m_we) begin
            m_ack_at = n + 2;
          end else begin
            m_ack_at    = -1;
            m_wait_from = n + 3;
          end
        end
      end else if (m_ack_at < 0 && n >= m_wait_from && mem_ready) begin
        e_dout   = mem_dout;
        m_ack_at = n + 1;
      end
      if (m_busy && m_ack_at == n + 1) begin
        e_ack = P'(1) << m_port;
        m_rr  = (m_port + 1) % P;
        model_acks++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b0;
    mem_dout  = '0;
    for (int p = 0; p < P; p++) begin
      r_act[p] = 1'b0; r_we[p] = 1'b0; r_addr[p] = '0; r_din[p] = '0; r_mask[p] = '0;
    end
    drive_ports();
    m_busy = 1'b0; m_port = 0; m_we = 1'b0; m_ack_at = -1; m_wait_from = 0; m_rr = 0;
    e_ack = '0; e_we = 1'b0; e_re = 1'b0;
    e_addr = '0; e_din = '0; e_mask = '0; e_dout = '0;
    model_acks = 0; dut_acks = 0; force_low = 1'b0; bp_left = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);

    for (int n = 0; n < NCYC; n++) begin
      // Outputs of cycle n against the model's prediction
      check_eq("ack_out",  ack_out,  e_ack);
      check_eq("mem_we",   mem_we,   e_we);
      check_eq("mem_re",   mem_re,   e_re);
      check_eq("mem_addr", mem_addr, e_addr);
      check_eq("mem_din",  mem_din,  e_din);
      check_eq("mem_mask", mem_mask, e_mask);
      check_eq("dout_out", dout_out, e_dout);
      if (ack_out != '0) dut_acks++;

      // Requesters: after an ack either drop or present a fresh request
      for (int p = 0; p < P; p++) begin
        if (e_ack[p]) begin
          if (($urandom % 2) == 0) new_request(p);
          else r_act[p] = 1'b0;
        end else if (!r_act[p] && ($urandom % 3) == 0) begin
          new_request(p);
        end
      end
      drive_ports();

      // sp_dram responder: ready drops the cycle after re, plus random
      // single-cycle dips and occasional 20-cycle back-pressure bursts
      if (bp_left == 0 && ($urandom % 150) == 0) bp_left = 20;
      if (force_low || bp_left > 0) mem_ready = 1'b0;
      else mem_ready = ($urandom % 4) != 0;
      if (bp_left > 0) bp_left--;
      force_low = e_re;
      mem_dout  = {$urandom, $urandom, $urandom, $urandom};

      // Occasional reset while a read is waiting for completion
      rst = (m_busy && !m_we && m_ack_at < 0 && n >= m_wait_from &&
             ($urandom % 20) == 0);

      model_step(n);
      @(negedge clk);
    end

    check_eq("ack_count", 128'(dut_acks), 128'(model_acks));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
